// File: rtl/nf10_l2_rewrite_pkg.sv
// Shared constants, FSM encoding and helpers for the router L2 header-rewrite stage.
// Field positions are bit offsets inside the top 256 bits of the data bus.
package nf10_l2_rewrite_pkg;

    localparam int unsigned DMAC_LO  = 208;
    localparam int unsigned SMAC_LO  = 160;
    localparam int unsigned TTL_LO   = 72;
    localparam int unsigned CKSUM_LO = 48;
    localparam int unsigned MAC_W    = 48;
    localparam int unsigned TTL_W    = 8;
    localparam int unsigned CKSUM_W  = 16;

    localparam logic [0:0] ST_HDR  = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;

    typedef enum logic [1:0] {
        DEC_FWD,
        DEC_BAD_OQ,
        DEC_ARP_MISS,
        DEC_TTL_EXP
    } route_dec_t;

    // True only for a single physical-port bit (even position) of an existing port.
    function automatic logic onehot_phys_port(input logic [7:0] oq, input int unsigned num_ports);
        logic ok;
        ok = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < num_ports && oq == 8'(1 << (2 * i))) begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: the head entry is visible on dout whenever !empty.
module fallthrough_small_fifo #(
    parameter int unsigned WIDTH          = 72,
    parameter int unsigned MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);

    localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] DEPTH_L = (MAX_DEPTH_BITS + 1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] NFULL_L = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;
    logic                      do_wr;
    logic                      do_rd;

    assign do_wr       = wr_en && (depth != DEPTH_L);
    assign do_rd       = rd_en && (depth != '0);
    assign dout        = mem[rd_ptr];
    assign empty       = (depth == '0);
    assign nearly_full = (depth >= NFULL_L);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                depth <= depth + 1'b1;
            end else if (!do_wr && do_rd) begin
                depth <= depth - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ipv4_ttl_cksum_update.sv
// Combinational IPv4 TTL decrement with RFC1624-style incremental checksum fix-up.
module ipv4_ttl_cksum_update (
    input  logic [7:0]  ttl,
    input  logic [15:0] cksum,
    output logic [7:0]  ttl_dec,
    output logic [15:0] cksum_upd
);

    logic [16:0] sum;

    // TTL is the high byte of its 16-bit word, so the stored checksum grows by 0x0100.
    assign sum       = {1'b0, cksum} + 17'h00100;
    assign cksum_upd = sum[15:0] + {15'b0, sum[16]};
    assign ttl_dec   = ttl - 8'd1;

endmodule

// File: rtl/nf10_l2_rewrite.sv
// Router output stage: consumes a lookup per routed header, rewrites MACs/TTL/checksum
// and selects the output queue, diverting exceptions to the source port's CPU queue.
module nf10_l2_rewrite
    import nf10_l2_rewrite_pkg::*;
#(
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned SRC_PORT_POS         = 16,
    parameter int unsigned DST_PORT_POS         = 24,
    parameter int unsigned NUM_PORTS            = 4,
    parameter int unsigned FIFO_DEPTH_BITS      = 2,
    parameter int unsigned C_S_AXI_DATA_WIDTH   = 32
) (
    input  logic                                AXI_ACLK,
    input  logic                                AXI_RESET,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
    input  logic                                S_AXIS_TVALID,
    input  logic                                S_AXIS_TLAST,
    output logic                                S_AXIS_TREADY,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
    output logic                                M_AXIS_TVALID,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY,

    input  logic [48*NUM_PORTS-1:0]             port_macs,
    input  logic                                lookup_valid,
    input  logic                                lookup_hit,
    input  logic [7:0]                          lookup_oq,
    input  logic [47:0]                         lookup_next_mac,
    output logic                                lookup_ready,

    input  logic                                counter_clear,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       forwarded_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       arp_miss_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       ttl_expired_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       bad_oq_count
);

    localparam int unsigned DW   = C_M_AXIS_DATA_WIDTH;
    localparam int unsigned UW   = C_M_AXIS_TUSER_WIDTH;
    localparam int unsigned SW   = C_M_AXIS_DATA_WIDTH / 8;
    localparam int unsigned FW   = C_S_AXIS_DATA_WIDTH + C_S_AXIS_TUSER_WIDTH + C_S_AXIS_DATA_WIDTH / 8 + 1;
    localparam int unsigned HOFF = DW - 256;
    localparam int unsigned CW   = C_S_AXI_DATA_WIDTH;

    logic [FW-1:0]    fifo_dout;
    logic             fifo_nearly_full;
    logic             fifo_empty;
    logic [DW-1:0]    h_tdata;
    logic [UW-1:0]    h_tuser;
    logic [SW-1:0]    h_tstrb;
    logic             h_tlast;

    logic [0:0]       state;
    logic [7:0]       src_port;
    logic [7:0]       dst_in;
    logic [7:0]       cpu_dst;
    logic             cpu_found;
    logic [47:0]      port_mac;
    logic [7:0]       h_ttl;
    logic [15:0]      h_cksum;
    logic [7:0]       new_ttl;
    logic [15:0]      new_cksum;
    route_dec_t       dec;
    logic             routed_hdr;
    logic             out_valid;
    logic             xfer;
    logic             hdr_take;
    logic [DW-1:0]    out_tdata;
    logic [UW-1:0]    out_tuser;

    fallthrough_small_fifo #(
        .WIDTH          (FW),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_in_fifo (
        .clk         (AXI_ACLK),
        .reset       (AXI_RESET),
        .din         ({S_AXIS_TDATA, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TLAST}),
        .wr_en       (S_AXIS_TVALID && !fifo_nearly_full),
        .rd_en       (xfer),
        .dout        (fifo_dout),
        .nearly_full (fifo_nearly_full),
        .empty       (fifo_empty)
    );

    assign {h_tdata, h_tuser, h_tstrb, h_tlast} = fifo_dout;
    assign S_AXIS_TREADY = !fifo_nearly_full;

    assign src_port = h_tuser[SRC_PORT_POS +: 8];
    assign dst_in   = h_tuser[DST_PORT_POS +: 8];
    assign h_ttl    = h_tdata[HOFF + TTL_LO +: TTL_W];
    assign h_cksum  = h_tdata[HOFF + CKSUM_LO +: CKSUM_W];

    ipv4_ttl_cksum_update u_ttl_cksum (
        .ttl       (h_ttl),
        .cksum     (h_cksum),
        .ttl_dec   (new_ttl),
        .cksum_upd (new_cksum)
    );

    // Exceptions go to the CPU queue paired with the lowest-numbered source port.
    always_comb begin
        cpu_dst   = '0;
        cpu_found = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!cpu_found && src_port[2*i]) begin
                cpu_dst[2*i+1] = 1'b1;
                cpu_found      = 1'b1;
            end
        end
    end

    always_comb begin
        port_mac = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (lookup_oq[2*i]) begin
                port_mac = port_macs[48*i +: 48];
            end
        end
    end

    always_comb begin
        dec = DEC_FWD;
        if (lookup_hit && !onehot_phys_port(lookup_oq, NUM_PORTS)) begin
            dec = DEC_BAD_OQ;
        end else if (!lookup_hit) begin
            dec = DEC_ARP_MISS;
        end else if (h_ttl <= 8'd1) begin
            dec = DEC_TTL_EXP;
        end
    end

    assign routed_hdr = (state == ST_HDR) && (dst_in == 8'd0);
    assign out_valid  = !fifo_empty && (!routed_hdr || lookup_valid);
    assign xfer       = out_valid && M_AXIS_TREADY;
    assign hdr_take   = routed_hdr && xfer;

    always_comb begin
        out_tdata = h_tdata;
        out_tuser = h_tuser;
        if (routed_hdr) begin
            if (dec == DEC_FWD) begin
                out_tdata[HOFF + DMAC_LO  +: MAC_W]   = lookup_next_mac;
                out_tdata[HOFF + SMAC_LO  +: MAC_W]   = port_mac;
                out_tdata[HOFF + TTL_LO   +: TTL_W]   = new_ttl;
                out_tdata[HOFF + CKSUM_LO +: CKSUM_W] = new_cksum;
                out_tuser[DST_PORT_POS +: 8]          = lookup_oq;
            end else begin
                out_tuser[DST_PORT_POS +: 8]          = cpu_dst;
            end
        end
    end

    assign M_AXIS_TDATA  = out_tdata;
    assign M_AXIS_TUSER  = out_tuser;
    assign M_AXIS_TSTRB  = h_tstrb;
    assign M_AXIS_TLAST  = h_tlast;
    assign M_AXIS_TVALID = out_valid;
    assign lookup_ready  = hdr_take;

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            state <= ST_HDR;
        end else if (xfer) begin
            if (state == ST_HDR && !h_tlast) begin
                state <= ST_BODY;
            end else if (state == ST_BODY && h_tlast) begin
                state <= ST_HDR;
            end
        end
    end

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET || counter_clear) begin
            forwarded_count   <= '0;
            arp_miss_count    <= '0;
            ttl_expired_count <= '0;
            bad_oq_count      <= '0;
        end else if (hdr_take) begin
            case (dec)
                DEC_FWD:      forwarded_count   <= sat_inc(forwarded_count);
                DEC_BAD_OQ:   bad_oq_count      <= sat_inc(bad_oq_count);
                DEC_ARP_MISS: arp_miss_count    <= sat_inc(arp_miss_count);
                DEC_TTL_EXP:  ttl_expired_count <= sat_inc(ttl_expired_count);
                default:      forwarded_count   <= forwarded_count;
            endcase
        end
    end

endmodule

// File: tb/tb_nf10_l2_rewrite.sv
// Randomised bench for nf10_l2_rewrite with a packet-level reference model and scoreboard.
module tb_nf10_l2_rewrite;

    localparam int DW   = 256;
    localparam int UW   = 128;
    localparam int SW   = 32;
    localparam int NP   = 4;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            AXI_RESET;
    logic [DW-1:0]   S_AXIS_TDATA;
    logic [SW-1:0]   S_AXIS_TSTRB;
    logic [UW-1:0]   S_AXIS_TUSER;
    logic            S_AXIS_TVALID;
    logic            S_AXIS_TLAST;
    logic            S_AXIS_TREADY;
    logic [DW-1:0]   M_AXIS_TDATA;
    logic [SW-1:0]   M_AXIS_TSTRB;
    logic [UW-1:0]   M_AXIS_TUSER;
    logic            M_AXIS_TVALID;
    logic            M_AXIS_TLAST;
    logic            M_AXIS_TREADY;
    logic [48*NP-1:0] port_macs;
    logic            lookup_valid;
    logic            lookup_hit;
    logic [7:0]      lookup_oq;
    logic [47:0]     lookup_next_mac;
    logic            lookup_ready;
    logic            counter_clear;
    logic [CW-1:0]   forwarded_count, arp_miss_count, ttl_expired_count, bad_oq_count;

    nf10_l2_rewrite #(
        .C_M_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_M_AXIS_TUSER_WIDTH (UW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .SRC_PORT_POS         (16),
        .DST_PORT_POS         (24),
        .NUM_PORTS            (NP),
        .FIFO_DEPTH_BITS      (2),
        .C_S_AXI_DATA_WIDTH   (CW)
    ) dut (
        .AXI_ACLK          (clk),
        .AXI_RESET         (AXI_RESET),
        .S_AXIS_TDATA      (S_AXIS_TDATA),
        .S_AXIS_TSTRB      (S_AXIS_TSTRB),
        .S_AXIS_TUSER      (S_AXIS_TUSER),
        .S_AXIS_TVALID     (S_AXIS_TVALID),
        .S_AXIS_TLAST      (S_AXIS_TLAST),
        .S_AXIS_TREADY     (S_AXIS_TREADY),
        .M_AXIS_TDATA      (M_AXIS_TDATA),
        .M_AXIS_TSTRB      (M_AXIS_TSTRB),
        .M_AXIS_TUSER      (M_AXIS_TUSER),
        .M_AXIS_TVALID     (M_AXIS_TVALID),
        .M_AXIS_TLAST      (M_AXIS_TLAST),
        .M_AXIS_TREADY     (M_AXIS_TREADY),
        .port_macs         (port_macs),
        .lookup_valid      (lookup_valid),
        .lookup_hit        (lookup_hit),
        .lookup_oq         (lookup_oq),
        .lookup_next_mac   (lookup_next_mac),
        .lookup_ready      (lookup_ready),
        .counter_clear     (counter_clear),
        .forwarded_count   (forwarded_count),
        .arp_miss_count    (arp_miss_count),
        .ttl_expired_count (ttl_expired_count),
        .bad_oq_count      (bad_oq_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic [SW-1:0] s;
        logic          l;
        logic          lk;
        int            kind;
    } beat_t;

    typedef struct {
        logic        hit;
        logic [7:0]  oq;
        logic [47:0] mac;
    } lk_t;

    beat_t exp_q[$];
    lk_t   lk_q[$];

    int checks = 0;
    int errors = 0;
    int m_fwd = 0, m_miss = 0, m_ttl = 0, m_bad = 0;
    int lk_pulses = 0;
    int s_xfers = 0;
    int rdy_mode = 1;
    int lk_delay = 0;
    bit lk_rand = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: what the router must emit for a header beat, from the forwarding rules.
    function automatic void model_hdr(input logic [DW-1:0] d, input logic [UW-1:0] u, input lk_t lk,
                                      output logic [DW-1:0] od, output logic [UW-1:0] ou,
                                      output logic uses, output int kind);
        logic [7:0] dst;
        logic [7:0] src;
        int cpu;
        int ttl;
        int c;
        int idx;
        dst = u[31:24];
        src = u[23:16];
        ttl = int'(d[79:72]);
        c   = int'(d[63:48]);
        cpu = 0;
        idx = -1;
        od = d;
        ou = u;
        uses = 1'b0;
        kind = 0;
        if (dst == 8'd0) begin
            uses = 1'b1;
            for (int i = NP - 1; i >= 0; i--) if (src[2*i]) cpu = 1 << (2 * i + 1);
            for (int i = 0; i < NP; i++) if (lk.oq == 8'(1 << (2 * i))) idx = i;
            if (lk.hit && idx < 0) begin
                kind = 4;
                ou[31:24] = 8'(cpu);
            end else if (!lk.hit) begin
                kind = 2;
                ou[31:24] = 8'(cpu);
            end else if (ttl <= 1) begin
                kind = 3;
                ou[31:24] = 8'(cpu);
            end else begin
                kind = 1;
                od[255:208] = lk.mac;
                od[207:160] = port_macs[48*idx +: 48];
                od[79:72]   = 8'(ttl - 1);
                c = c + 256;
                if (c > 65535) c = c - 65536 + 1;
                od[63:48]   = 16'(c);
                ou[31:24]   = lk.oq;
            end
        end
    endfunction

    task automatic finish_now();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "bench stopped early");
    endtask

    task automatic drive_beat(input logic [DW-1:0] d, input logic [UW-1:0] u, input logic [SW-1:0] s, input logic l);
        int n;
        n = 0;
        S_AXIS_TDATA  = d;
        S_AXIS_TUSER  = u;
        S_AXIS_TSTRB  = s;
        S_AXIS_TLAST  = l;
        S_AXIS_TVALID = 1'b1;
        @(negedge clk);
        while (!S_AXIS_TREADY) begin
            n++;
            if (n > 2000) begin
                errors++;
                checks++;
                $display("FAIL input_timeout: S_AXIS_TREADY stuck low for %0d cycles, required high", n);
                finish_now();
            end
            @(negedge clk);
        end
        tick();
        S_AXIS_TVALID = 1'b0;
    endtask

    task automatic send_pkt(input int nb, input logic [DW-1:0] hd, input logic [UW-1:0] hu, input lk_t lk);
        beat_t b;
        beat_t beats[$];
        logic [DW-1:0] od;
        logic [UW-1:0] ou;
        logic uses;
        int kind;
        model_hdr(hd, hu, lk, od, ou, uses, kind);
        for (int i = 0; i < nb; i++) begin
            b.d = (i == 0) ? hd : rnd256();
            b.u = (i == 0) ? hu : {$urandom, $urandom, $urandom, $urandom};
            b.s = $urandom;
            b.l = (i == nb - 1);
            b.lk = 1'b0;
            b.kind = 0;
            beats.push_back(b);
            if (i == 0) begin
                b.d = od;
                b.u = ou;
                b.lk = uses;
                b.kind = kind;
            end
            exp_q.push_back(b);
        end
        if (uses) lk_q.push_back(lk);
        foreach (beats[i]) drive_beat(beats[i].d, beats[i].u, beats[i].s, beats[i].l);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats still outstanding, required 0", exp_q.size());
        end
        tick();
        tick();
    endtask

    function automatic logic [DW-1:0] mk_hdr(input int ttl, input int ck);
        logic [DW-1:0] d;
        d = rnd256();
        d[79:72] = 8'(ttl);
        d[63:48] = 16'(ck);
        return d;
    endfunction

    function automatic logic [UW-1:0] mk_user(input logic [7:0] dst, input logic [7:0] src);
        logic [UW-1:0] u;
        u = {$urandom, $urandom, $urandom, $urandom};
        u[31:24] = dst;
        u[23:16] = src;
        return u;
    endfunction

    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
            1:       M_AXIS_TREADY = 1'b1;
            default: M_AXIS_TREADY = 1'b0;
        endcase
    end

    // Lookup engine stand-in: answers routed headers in arrival order.
    initial begin
        lookup_valid = 1'b0;
        lookup_hit = 1'b0;
        lookup_oq = '0;
        lookup_next_mac = '0;
        forever begin
            if (lk_q.size() == 0) begin
                lookup_valid = 1'b0;
                tick();
            end else begin
                int dly;
                dly = lk_rand ? $urandom_range(0, 3) : lk_delay;
                if (dly > 0) begin
                    lookup_valid = 1'b0;
                    repeat (dly) tick();
                end
                lookup_hit      = lk_q[0].hit;
                lookup_oq       = lk_q[0].oq;
                lookup_next_mac = lk_q[0].mac;
                lookup_valid    = 1'b1;
                @(negedge clk);
                while (!lookup_ready) @(negedge clk);
                tick();
                void'(lk_q.pop_front());
            end
        end
    end

    beat_t e;
    always @(negedge clk) begin
        if (AXI_RESET) begin
            m_fwd = 0; m_miss = 0; m_ttl = 0; m_bad = 0;
            exp_q.delete();
        end else begin
            check("forwarded_count", DW'(forwarded_count), DW'(m_fwd));
            check("arp_miss_count", DW'(arp_miss_count), DW'(m_miss));
            check("ttl_expired_count", DW'(ttl_expired_count), DW'(m_ttl));
            check("bad_oq_count", DW'(bad_oq_count), DW'(m_bad));
            if (exp_q.size() > 0 && exp_q[0].lk && !lookup_valid)
                check("tvalid_waits_lookup", DW'(M_AXIS_TVALID), DW'(0));
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got a beat, required none");
                end else begin
                    e = exp_q.pop_front();
                    check("tdata", M_AXIS_TDATA, e.d);
                    check("tuser", DW'(M_AXIS_TUSER), DW'(e.u));
                    check("tstrb", DW'(M_AXIS_TSTRB), DW'(e.s));
                    check("tlast", DW'(M_AXIS_TLAST), DW'(e.l));
                    check("lookup_ready_on_xfer", DW'(lookup_ready), DW'(e.lk));
                    if (lookup_ready) lk_pulses++;
                    if (!counter_clear && e.lk) begin
                        case (e.kind)
                            1: if (m_fwd < CMAX) m_fwd++;
                            2: if (m_miss < CMAX) m_miss++;
                            3: if (m_ttl < CMAX) m_ttl++;
                            4: if (m_bad < CMAX) m_bad++;
                            default: ;
                        endcase
                    end
                end
            end else begin
                check("lookup_ready_idle", DW'(lookup_ready), DW'(0));
            end
            if (counter_clear) begin
                m_fwd = 0; m_miss = 0; m_ttl = 0; m_bad = 0;
            end
            if (S_AXIS_TVALID && S_AXIS_TREADY) s_xfers++;
        end
    end

    initial begin
        #500000;
        checks++;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        finish_now();
    end

    initial begin
        logic [DW-1:0] d, od;
        logic [UW-1:0] u, ou;
        logic uses;
        int kind;
        int p0, sx0;
        lk_t lk;

        port_macs = {48'h02005E100004, 48'h02005E100003, 48'h02005E100002, 48'h02005E100001};
        AXI_RESET = 1'b1;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TDATA = '0;
        S_AXIS_TUSER = '0;
        S_AXIS_TSTRB = '0;
        S_AXIS_TLAST = 1'b0;
        counter_clear = 1'b0;
        M_AXIS_TREADY = 1'b1;
        repeat (3) tick();
        AXI_RESET = 1'b0;
        tick();

        check("rst_tvalid", DW'(M_AXIS_TVALID), DW'(0));
        check("rst_lookup_ready", DW'(lookup_ready), DW'(0));
        check("rst_sready", DW'(S_AXIS_TREADY), DW'(1));
        check("rst_fwd_cnt", DW'(forwarded_count), DW'(0));

        // Basic forward, 3 beats
        d = mk_hdr(64, 16'h1234);
        u = mk_user(8'h00, 8'h01);
        lk = '{1'b1, 8'h04, 48'h0A0B0C0D0E0F};
        model_hdr(d, u, lk, od, ou, uses, kind);
        check("model_dmac", DW'(od[255:208]), DW'(48'h0A0B0C0D0E0F));
        check("model_smac", DW'(od[207:160]), DW'(48'h02005E100002));
        check("model_ttl", DW'(od[79:72]), DW'(63));
        check("model_cksum", DW'(od[63:48]), DW'(16'h1334));
        check("model_dst", DW'(ou[31:24]), DW'(8'h04));
        p0 = lk_pulses;
        send_pkt(3, d, u, lk);
        drain();
        check("fwd_count_1", DW'(forwarded_count), DW'(1));
        check("one_lookup_pulse", DW'(lk_pulses - p0), DW'(1));

        // Checksum end-around carry
        d = mk_hdr(10, 16'hFF00);
        u = mk_user(8'h00, 8'h01);
        lk = '{1'b1, 8'h01, 48'h112233445566};
        model_hdr(d, u, lk, od, ou, uses, kind);
        check("model_wrap_cksum", DW'(od[63:48]), DW'(16'h0001));
        check("model_wrap_ttl", DW'(od[79:72]), DW'(9));
        send_pkt(1, d, u, lk);
        drain();
        check("fwd_count_2", DW'(forwarded_count), DW'(2));

        // TTL expiry at 1 and 0
        for (int t = 1; t >= 0; t--) begin
            d = mk_hdr(t, $urandom);
            u = mk_user(8'h00, 8'h10);
            lk = '{1'b1, 8'h04, 48'h0A0B0C0D0E0F};
            model_hdr(d, u, lk, od, ou, uses, kind);
            check("model_ttl_dst", DW'(ou[31:24]), DW'(8'h20));
            check("model_ttl_hdr", od, d);
            send_pkt(2, d, u, lk);
            drain();
        end
        check("ttl_exp_count_2", DW'(ttl_expired_count), DW'(2));

        // ARP miss, then bad OQ
        d = mk_hdr(30, $urandom);
        u = mk_user(8'h00, 8'h40);
        lk = '{1'b0, 8'h04, 48'h0};
        model_hdr(d, u, lk, od, ou, uses, kind);
        check("model_miss_dst", DW'(ou[31:24]), DW'(8'h80));
        send_pkt(1, d, u, lk);
        drain();
        check("arp_miss_count_1", DW'(arp_miss_count), DW'(1));
        d = mk_hdr(30, $urandom);
        lk = '{1'b1, 8'h06, 48'h0};
        model_hdr(d, u, lk, od, ou, uses, kind);
        check("model_bad_dst", DW'(ou[31:24]), DW'(8'h80));
        send_pkt(1, d, u, lk);
        drain();
        check("bad_oq_count_1", DW'(bad_oq_count), DW'(1));

        // Backpressure: output stalled, lookup late, FIFO fills
        rdy_mode = 2;
        lk_delay = 3;
        tick();
        p0 = lk_pulses;
        sx0 = s_xfers;
        fork
            send_pkt(5, mk_hdr(20, $urandom), mk_user(8'h00, 8'h04), '{1'b1, 8'h10, 48'hCAFE0000BEEF});
            begin
                repeat (8) tick();
                check("sready_nearly_full", DW'(S_AXIS_TREADY), DW'(0));
                check("fifo_accepted", DW'(s_xfers - sx0), DW'(3));
                check("hdr_held_valid", DW'(M_AXIS_TVALID), DW'(1));
                rdy_mode = 1;
            end
        join
        drain();
        check("bp_one_lookup_pulse", DW'(lk_pulses - p0), DW'(1));
        check("fwd_count_3", DW'(forwarded_count), DW'(3));

        // Randomised traffic
        rdy_mode = 0;
        lk_rand = 1'b1;
        for (int n = 0; n < 150; n++) begin
            int r;
            u = mk_user(($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 8'($urandom));
            d = mk_hdr(($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(2, 255),
                       ($urandom_range(0, 3) == 0) ? $urandom_range(16'hFF00, 16'hFFFF) : $urandom_range(0, 16'hFFFF));
            r = $urandom_range(0, 5);
            lk.hit = ($urandom_range(0, 4) != 0);
            lk.oq  = (r < 4) ? 8'(1 << (2 * r)) : 8'($urandom);
            lk.mac = 48'({$urandom, $urandom});
            send_pkt($urandom_range(1, 4), d, u, lk);
        end
        drain();

        // Saturation of the forwarded counter
        rdy_mode = 1;
        for (int n = 0; n < 70; n++)
            send_pkt(1, mk_hdr(50, $urandom), mk_user(8'h00, 8'h01), '{1'b1, 8'h40, 48'h00AA00BB00CC});
        drain();
        check("fwd_saturated", DW'(forwarded_count), DW'(CMAX));

        // Clear wins over a coincident increment
        counter_clear = 1'b1;
        send_pkt(1, mk_hdr(1, $urandom), mk_user(8'h00, 8'h01), '{1'b1, 8'h01, 48'h0});
        drain();
        counter_clear = 1'b0;
        tick();
        check("clear_fwd", DW'(forwarded_count), DW'(0));
        check("clear_ttl", DW'(ttl_expired_count), DW'(0));
        check("clear_miss", DW'(arp_miss_count), DW'(0));
        check("clear_bad", DW'(bad_oq_count), DW'(0));

        // Reset while the FSM is in BODY
        d = rnd256();
        u = mk_user(8'h01, 8'h01);
        for (int i = 0; i < 3; i++) exp_q.push_back('{(i == 0) ? d : rnd256(), u, '1, (i == 2), 1'b0, 0});
        drive_beat(d, u, '1, 1'b0);
        p0 = 0;
        while (exp_q.size() > 2 && p0 < 50) begin
            tick();
            p0++;
        end
        rdy_mode = 2;
        tick();
        drive_beat(rnd256(), u, '1, 1'b0);
        AXI_RESET = 1'b1;
        repeat (2) tick();
        AXI_RESET = 1'b0;
        tick();
        check("mid_rst_flushed", DW'(M_AXIS_TVALID), DW'(0));
        rdy_mode = 1;
        send_pkt(2, mk_hdr(64, 16'h1234), mk_user(8'h00, 8'h01), '{1'b1, 8'h04, 48'h0A0B0C0D0E0F});
        drain();
        check("post_rst_fwd", DW'(forwarded_count), DW'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
